// File: rtl/layer_ser_if.sv
// layer_ser_if: producer-vector in / serial-word out bundle for layer_serializer.
interface layer_ser_if #(
    parameter int NN        = 30,
    parameter int dataWidth = 16
);
    localparam int IDX_W = (NN > 1) ? $clog2(NN) : 1;
    logic [NN-1:0]           in_valid;
    logic [NN*dataWidth-1:0] in_data;
    logic                    err_clr;
    logic [dataWidth-1:0]    out_data;
    logic                    out_valid;
    logic                    busy;
    logic                    err_overrun;
    logic                    err_partial;
    logic [IDX_W-1:0]        max_idx;
    logic                    max_valid;
    modport master (
        output in_valid, in_data, err_clr,
        input  out_data, out_valid, busy, err_overrun, err_partial, max_idx, max_valid
    );
    modport slave (
        input  in_valid, in_data, err_clr,
        output out_data, out_valid, busy, err_overrun, err_partial, max_idx, max_valid
    );
endinterface

// File: rtl/layer_serializer.sv
// layer_serializer: captures a full layer output vector and replays it one word per clock.
// Define LAYER_SER_ARGMAX_EN to add the signed argmax output stage.
module layer_serializer #(
    parameter int NN        = 30,
    parameter int dataWidth = 16
) (
    input logic       clk,
    input logic       rst,
    layer_ser_if.slave bus
);
    localparam int IDX_W = (NN > 1) ? $clog2(NN) : 1;
    localparam int CW    = $clog2(NN + 1);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]              r_state;
    logic [CW-1:0]           r_cnt;
    logic [NN*dataWidth-1:0] r_buf;
    logic [dataWidth-1:0]    r_out_data;
    logic                    r_out_valid;
    logic                    r_busy;
    logic                    r_err_ovr;
    logic                    r_err_part;
    logic                    w_cap;
    logic                    w_partial;
    logic                    w_last;
    logic                    w_reload;
    logic                    w_overrun;

    assign w_cap     = &bus.in_valid;
    assign w_partial = |bus.in_valid & ~w_cap;
    // r_cnt indexes the next word, so NN means the last word is on the output now
    assign w_last    = (r_state == SHIFT) && (r_cnt == CW'(NN));
    assign w_reload  = w_cap & ((r_state == IDLE) | w_last);
    assign w_overrun = w_cap & (r_state == SHIFT) & ~w_last;

    always_ff @(posedge clk)
        if (w_reload) r_buf <= bus.in_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_err_ovr   <= 1'b0;
            r_err_part  <= 1'b0;
        end else begin
            if (w_reload) begin
                r_state     <= SHIFT;
                r_out_data  <= bus.in_data[dataWidth-1:0];
                r_out_valid <= 1'b1;
                r_busy      <= 1'b1;
                r_cnt       <= CW'(1);
            end else if (w_last) begin
                r_state     <= IDLE;
                r_out_valid <= 1'b0;
                r_busy      <= 1'b0;
            end else if (r_state == SHIFT) begin
                r_out_data <= r_buf[r_cnt*dataWidth +: dataWidth];
                r_cnt      <= r_cnt + CW'(1);
            end
            r_err_ovr  <= ~bus.err_clr & (r_err_ovr | w_overrun);
            r_err_part <= ~bus.err_clr & (r_err_part | w_partial);
        end
    end

    assign bus.out_data    = r_out_data;
    assign bus.out_valid   = r_out_valid;
    assign bus.busy        = r_busy;
    assign bus.err_overrun = r_err_ovr;
    assign bus.err_partial = r_err_part;

`ifdef LAYER_SER_ARGMAX_EN
    logic signed [dataWidth-1:0] r_run_max;
    logic [IDX_W-1:0]            r_run_idx;
    logic [IDX_W-1:0]            r_max_idx;
    logic                        r_max_valid;
    logic [IDX_W-1:0]            w_cur_idx;
    logic                        w_take;

    // strict compare keeps the lower index on ties; word0 always seeds the max
    assign w_cur_idx = IDX_W'(r_cnt - CW'(1));
    assign w_take    = (r_cnt == CW'(1)) || ($signed(r_out_data) > r_run_max);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run_max   <= '0;
            r_run_idx   <= '0;
            r_max_idx   <= '0;
            r_max_valid <= 1'b0;
        end else begin
            r_max_valid <= w_last;
            if (r_state == SHIFT && w_take) begin
                r_run_max <= $signed(r_out_data);
                r_run_idx <= w_cur_idx;
            end
            if (w_last) r_max_idx <= w_take ? w_cur_idx : r_run_idx;
        end
    end

    assign bus.max_idx   = r_max_idx;
    assign bus.max_valid = r_max_valid;
`else
    assign bus.max_idx   = '0;
    assign bus.max_valid = 1'b0;
`endif
endmodule
